// File: rtl/fpu_norm_stage.sv
// Two-stage normalization pipeline: stage A captures the operand and its leading-zero
// count, and stage B shifts the mantissa and adjusts the exponent, clamping at subnormal.

package fpu_norm_pkg;
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction
endpackage

// Leading (MODE=1) or trailing (MODE=0) zero counter; cnt_o is 0 when the input is all-zero.
module lzc #(
  parameter int WIDTH     = 8,
  parameter bit MODE      = 1'b0,
  parameter int CNT_WIDTH = fpu_norm_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    cnt_o   = '0;
    empty_o = ~|in_i;
    // Scan from the far end toward the counted end so the last hit wins.
    for (int k = 0; k < WIDTH; k++) begin
      if (in_i[MODE ? k : WIDTH-1-k]) cnt_o = CNT_WIDTH'(WIDTH - 1 - k);
    end
  end

endmodule

module fpu_norm_stage #(
  parameter int MAN_WIDTH = 28,
  parameter int EXP_WIDTH = 10,
  // Derived from MAN_WIDTH; leave at its default.
  parameter int CNT_WIDTH = fpu_norm_pkg::idx_width(MAN_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_sign_i,
  input  logic [EXP_WIDTH-1:0] in_exp_i,
  input  logic [MAN_WIDTH-1:0] in_man_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_sign_o,
  output logic [EXP_WIDTH-1:0] out_exp_o,
  output logic [MAN_WIDTH-1:0] out_man_o,
  output logic                 out_zero_o,
  output logic                 out_denorm_o
);

  localparam int EW1 = EXP_WIDTH + 1;
  localparam logic signed [EW1-1:0] EXP_ONE = EW1'(1);

  logic                 valid_a, valid_b;
  logic                 a_sign, a_zero;
  logic [EXP_WIDTH-1:0] a_exp;
  logic [MAN_WIDTH-1:0] a_man;
  logic [CNT_WIDTH-1:0] a_lz;

  logic [CNT_WIDTH-1:0] in_lz;
  logic                 in_zero;
  logic                 in_fire, a_fire;

  lzc #(
    .WIDTH    (MAN_WIDTH),
    .MODE     (1'b1),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_lzc (
    .in_i   (in_man_i),
    .cnt_o  (in_lz),
    .empty_o(in_zero)
  );

  assign in_ready_o  = !valid_a || !valid_b || out_ready_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign a_fire      = valid_a && (!valid_b || out_ready_i);
  assign out_valid_o = valid_b;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else if (flush_i) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      if (in_fire)     valid_a <= 1'b1;
      else if (a_fire) valid_a <= 1'b0;
      if (a_fire)           valid_b <= 1'b1;
      else if (out_ready_i) valid_b <= 1'b0;
    end
  end

  // NOTE: stage A payload has no reset; it is only ever observed behind valid_a.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      a_sign <= in_sign_i;
      a_exp  <= in_exp_i;
      a_man  <= in_man_i;
      a_lz   <= in_lz;
      a_zero <= in_zero;
    end
  end

  logic signed [EW1-1:0] exp_ext, lz_ext, exp_diff;
  logic [CNT_WIDTH-1:0]  b_shift;
  logic [EXP_WIDTH-1:0]  b_exp;
  logic [MAN_WIDTH-1:0]  b_man;
  logic                  b_denorm;

  assign exp_ext  = $signed({a_exp[EXP_WIDTH-1], a_exp});
  assign lz_ext   = $signed(EW1'(a_lz));
  assign exp_diff = exp_ext - lz_ext;

  always_comb begin
    b_shift  = '0;
    b_exp    = '0;
    b_denorm = 1'b0;
    if (a_zero) begin
      b_denorm = 1'b0;
    end else if (exp_diff >= EXP_ONE) begin
      b_shift = a_lz;
      b_exp   = exp_diff[EXP_WIDTH-1:0];
    end else if (exp_ext > EXP_ONE) begin
      // Shift only as far as the exponent allows, landing on the subnormal boundary.
      b_shift  = CNT_WIDTH'(exp_ext - EXP_ONE);
      b_denorm = 1'b1;
    end else begin
      b_denorm = 1'b1;
    end
    b_man = a_man << b_shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_sign_o   <= 1'b0;
      out_exp_o    <= '0;
      out_man_o    <= '0;
      out_zero_o   <= 1'b0;
      out_denorm_o <= 1'b0;
    end else if (a_fire) begin
      out_sign_o   <= a_sign;
      out_exp_o    <= b_exp;
      out_man_o    <= b_man;
      out_zero_o   <= a_zero;
      out_denorm_o <= b_denorm;
    end
  end

endmodule

// File: tb/tb_fpu_norm_stage.sv
// Randomized scoreboard bench for fpu_norm_stage (MAN_WIDTH=8, EXP_WIDTH=6) with an
// arithmetic reference model, plus directed backpressure, flush and reset scenarios.

module tb_fpu_norm_stage;

  localparam int MW = 8;
  localparam int EW = 6;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] man;
    logic          zero;
    logic          denorm;
  } res_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_sign;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_man;
  logic          out_valid, out_ready, out_sign, out_zero, out_denorm;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_man;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];
  res_t held;
  bit   held_valid = 1'b0;
  bit   stop_tog;

  always #5 clk = ~clk;

  fpu_norm_stage #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_sign_i   (in_sign),
    .in_exp_i    (in_exp),
    .in_man_i    (in_man),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sign_o  (out_sign),
    .out_exp_o   (out_exp),
    .out_man_o   (out_man),
    .out_zero_o  (out_zero),
    .out_denorm_o(out_denorm)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: normalize so the MSB is set, unless the exponent would drop below 1.
  function automatic res_t model(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
    res_t r;
    int   ei = int'($signed(e));
    int   mi = int'(m);
    int   lz = 0;
    r.sign = s;
    r.zero = 1'b0;
    r.exp  = '0;
    if (mi == 0) begin
      r.man    = '0;
      r.zero   = 1'b1;
      r.denorm = 1'b0;
      return r;
    end
    while (mi < (1 << (MW - 1))) begin
      mi = mi * 2;
      lz++;
    end
    if (ei - lz >= 1) begin
      r.man    = MW'(mi);
      r.exp    = EW'(ei - lz);
      r.denorm = 1'b0;
    end else if (ei > 1) begin
      r.man    = MW'(int'(m) * (1 << (ei - 1)));
      r.denorm = 1'b1;
    end else begin
      r.man    = m;
      r.denorm = 1'b1;
    end
    return r;
  endfunction

  function automatic res_t cur_out();
    return {out_sign, out_exp, out_man, out_zero, out_denorm};
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks hold-stability under backpressure.
  always @(negedge clk) begin
    res_t cur, req;
    if (rst) begin
      held_valid = 1'b0;
    end else if (out_valid) begin
      cur = cur_out();
      if (held_valid) check("hold_stable", 32'(cur), 32'(held));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output at %0t", cur, $time);
        end else begin
          req = exp_q.pop_front();
          check("result", 32'(cur), 32'(req));
        end
        held_valid = 1'b0;
      end else begin
        held       = cur;
        held_valid = 1'b1;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic send(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m, input res_t r);
    bit accepted = 1'b0;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        exp_q.push_back(r);
        accepted = 1'b1;
        break;
      end
    end
    check("send_accepted", 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic          s = 1'($urandom);
    logic [EW-1:0] e = EW'($urandom_range(0, (1 << EW) - 1));
    logic [MW-1:0] m = MW'($urandom) >> $urandom_range(0, MW);
    send(s, e, m, model(s, e, m));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_complete", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = '0; in_man = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", 32'(cur_out()), 32'd0);
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Normal case with a two-cycle latency check.
    send(1'b0, 6'd10, 8'b0001_0110, '{1'b0, 6'd7, 8'b1011_0000, 1'b0, 1'b0});
    check("latency_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_cycle2", 32'(out_valid), 32'd1);
    drain();

    send(1'b0, 6'd4,  8'b0000_0011, '{1'b0, 6'd0, 8'b0001_1000, 1'b0, 1'b1});
    send(1'b1, 6'd0,  8'b0000_0101, '{1'b1, 6'd0, 8'b0000_0101, 1'b0, 1'b1});
    send(1'b1, 6'd20, 8'b0000_0000, '{1'b1, 6'd0, 8'b0000_0000, 1'b1, 1'b0});
    send(1'b0, 6'd1,  8'b1000_0000, '{1'b0, 6'd1, 8'b1000_0000, 1'b0, 1'b0});
    send(1'b0, 6'h3F, 8'b0100_0000, '{1'b0, 6'd0, 8'b0100_0000, 1'b0, 1'b1});
    drain();

    // Backpressure: three operands, downstream stalled for four cycles.
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 6'd9,  8'h01, model(1'b0, 6'd9,  8'h01));
        send(1'b1, 6'd3,  8'h22, model(1'b1, 6'd3,  8'h22));
        send(1'b0, 6'd30, 8'h7F, model(1'b0, 6'd30, 8'h7F));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Streaming at full rate with a flush pulse mid-stream.
    for (int i = 0; i < 16; i++) begin
      in_sign  = 1'($urandom);
      in_exp   = EW'($urandom);
      in_man   = MW'($urandom) >> $urandom_range(0, 4);
      in_valid = 1'b1;
      flush    = (i == 8);
      @(negedge clk);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i == 8) exp_q.delete();
      else        exp_q.push_back(model(in_sign, in_exp, in_man));
      @(posedge clk);
      #1;
      if (i >= 1 && i <= 7) check("stream_out_valid", 32'(out_valid), 32'd1);
      if (i == 8)           check("flush_out_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    drain();

    // Random traffic under random backpressure.
    stop_tog = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          send_rand();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        stop_tog = 1'b1;
      end
      begin
        while (!stop_tog) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages occupied.
    out_ready = 1'b0;
    send(1'b1, 6'd12, 8'h35, model(1'b1, 6'd12, 8'h35));
    send(1'b0, 6'd2,  8'h08, model(1'b0, 6'd2,  8'h08));
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("rst_full_out_valid", 32'(out_valid), 32'd0);
    check("rst_full_outputs", 32'(cur_out()), 32'd0);
    rst = 1'b0;
    check("rst_full_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nothing_emerges", 32'(out_valid), 32'd0);

    send(1'b0, 6'd5, 8'h03, model(1'b0, 6'd5, 8'h03));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_norm_stage.md
FPU_NORM_STAGE -- requirements
Module: fpu_norm_stage

Interface
REQ-001 Parameter MAN_WIDTH, default 28: mantissa width in bits; SHALL be >= 2.
REQ-002 Parameter EXP_WIDTH, default 10: exponent width in bits; the exponent is two's-complement signed and SHALL be >= 4.
REQ-003 Parameter CNT_WIDTH, derived as idx_width(MAN_WIDTH): width of the internal shift count; SHALL NOT be overridden.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 flush_i  in  1  synchronous pipeline flush.
REQ-007 in_valid_i  in  1  input operand valid.
REQ-008 in_ready_o  out  1  stage can accept an operand this cycle.
REQ-009 in_sign_i  in  1  operand sign.
REQ-010 in_exp_i  in  EXP_WIDTH  biased exponent, signed.
REQ-011 in_man_i  in  MAN_WIDTH  unnormalized mantissa, MSB is the hidden-bit position.
REQ-012 out_valid_o  out  1  result valid.
REQ-013 out_ready_i  in  1  downstream accepts the result.
REQ-014 out_sign_o  out  1  result sign.
REQ-015 out_exp_o  out  EXP_WIDTH  adjusted exponent.
REQ-016 out_man_o  out  MAN_WIDTH  normalized mantissa.
REQ-017 out_zero_o  out  1  result is zero.
REQ-018 out_denorm_o  out  1  result is subnormal (shift clamped by exponent).

Function
REQ-019 The block SHALL be a 2-stage pipeline (A, B), each with a valid register; a transfer occurs on valid && ready at each boundary.
REQ-020 Stage A SHALL capture sign, exponent, mantissa, leading-zero count lz and an all-zero flag on an input transfer; lz and the flag come from an lzc instance with MODE=1 and WIDTH=MAN_WIDTH.
REQ-021 Stage B SHALL compute the result from stage A registers and register it; the result is visible at out_* exactly 2 cycles after the input transfer when there is no backpressure.
REQ-022 Stage B advance: B SHALL load when A is valid and (B is empty or out_ready_i=1).
REQ-023 Stage A advance: in_ready_o SHALL equal !validA || !validB || out_ready_i; a combinational path from out_ready_i to in_ready_o is permitted.
REQ-024 Full throughput SHALL be 1 operand per cycle while out_ready_i=1.
REQ-025 While out_valid_o=1 and out_ready_i=0, all out_* SHALL hold stable.
REQ-026 Normal case (exp - lz >= 1): the mantissa SHALL be shifted left by lz, out_exp = exp - lz, and out_denorm=0.
REQ-027 Clamp case (exp - lz < 1 and exp > 1): the shift SHALL be exp - 1, out_exp = 0, and out_denorm=1.
REQ-028 Low-exponent case (exp <= 1 and exp - lz < 1): the shift SHALL be 0, the mantissa passes through unchanged, out_exp = 0, and out_denorm=1.
REQ-029 Zero mantissa SHALL produce out_man=0, out_exp=0, out_zero=1, out_denorm=0, with the sign preserved.
REQ-030 Exponent arithmetic SHALL be carried out at EXP_WIDTH+1 bits signed so that no wrap occurs; left shifts fill with zeros.
REQ-031 Simultaneous B drain and A refill in the same cycle SHALL lose and duplicate nothing.
REQ-032 flush_i=1 SHALL clear validA and validB at the next edge; an input presented in the same cycle SHALL be dropped; in_ready_o is unaffected by flush_i.

Reset
REQ-033 With rst_i=1 at a clock edge, validA, validB and out_valid_o SHALL be 0 after that edge; out_sign_o, out_exp_o, out_man_o, out_zero_o and out_denorm_o SHALL be 0.
REQ-034 in_ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset SHALL take priority over flush_i and any transfer.
REQ-036 Operands in flight when reset asserts SHALL be discarded.

Verification (bench uses MAN_WIDTH=8, EXP_WIDTH=6)
REQ-037 man=0001_0110, exp=10, sign=0, out_ready_i=1 -> 2 cycles later: man=1011_0000, exp=7, zero=0, denorm=0.
REQ-038 man=0000_0011, exp=4 (lz=6) -> man=0001_1000, exp=0, denorm=1; man=0000_0101, exp=0 -> man=0000_0101, exp=0, denorm=1.
REQ-039 man=0000_0000, exp=20, sign=1 -> man=0, exp=0, zero=1, denorm=0, sign=1.
REQ-040 3 back-to-back operands with out_ready_i=0 for 4 cycles -> in_ready_o=0 after 2 are accepted, outputs hold stable, then all 3 emerge in order with no loss or duplication.
REQ-041 Continuous stream with out_ready_i=1 -> one result per cycle; flush_i pulsed mid-stream -> the next cycle out_valid_o=0 and the flush-cycle input is dropped.
REQ-042 rst_i asserted with both stages full -> out_valid_o=0 and out_* all 0 next cycle; in_ready_o=1 after rst_i deasserts.
